jtag_mem_arbiter: RTL and testbench
===================================

JTAG_MEM_ARBITER -- requirements
Module: jtag_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, memory address width.
REQ-002 Parameter DATA_W, default 32, memory data width.
REQ-003 Parameter TIMEOUT, default 256, maximum cycles spent in REQ or RSP before an error completion.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 halt_i  input  1  CPU halted by debug; 1 blocks master-1 grants.
REQ-007 m0_req_i, m0_we_i  input  1 each  debug master request (level, held until ack) and write enable.
REQ-008 m0_addr_i  input  ADDR_W; m0_wdata_i  input  DATA_W  debug master command.
REQ-009 m0_ack_o, m0_err_o  output  1 each  debug master completion pulse and error flag.
REQ-010 m0_rdata_o  output  DATA_W  debug master read data.
REQ-011 m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_ack_o, m1_err_o, m1_rdata_o  same as m0_*  CPU master.
REQ-012 s_req_o, s_we_o  output  1 each; s_addr_o  output  ADDR_W; s_wdata_o  output  DATA_W  memory command.
REQ-013 s_gnt_i  input  1  memory accepted command; s_rvalid_i  input  1  completion (reads and writes); s_rdata_i  input  DATA_W.
REQ-014 busy_o  output  1  arbiter not in IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, REQ, RSP and DONE; every output SHALL be registered.
REQ-016 IDLE: eligible = m0_req_i, plus m1_req_i only when halt_i=0; none eligible -> stay IDLE.
REQ-017 Arbitration: single eligible -> grant it; both eligible -> grant the master not granted last (round-robin via last_grant).
REQ-018 On grant: latch owner, we, addr and wdata; update last_grant; go to REQ.
REQ-019 REQ: s_req_o=1 with latched command, stable until s_gnt_i=1; s_gnt_i=1 -> RSP, s_req_o=0 next cycle.
REQ-020 RSP: wait for s_rvalid_i; on it capture s_rdata_i (reads only) into owner's rdata register -> DONE.
REQ-021 DONE lasts exactly one cycle: owner's ack_o=1, err_o per REQ-023, then IDLE; a request still high in DONE is not re-sampled.
REQ-022 mX_rdata_o SHALL hold its value until that master's next read completion; writes leave it unchanged.
REQ-023 Timeout counter clears on entry to REQ and RSP; on reaching TIMEOUT cycles in either -> DONE with err_o=1 and owner rdata = 0.
REQ-024 Minimum latency with a zero-wait slave: grant edge -> REQ -> RSP -> DONE, ack 3 cycles after the request is sampled in IDLE.
REQ-025 s_gnt_i outside REQ and s_rvalid_i outside RSP SHALL be ignored.
REQ-026 halt_i rising during an m1 transaction SHALL NOT abort it; it affects only the next arbitration.
REQ-027 Only one transaction is outstanding at a time; the non-owner's ack_o and err_o stay 0.
REQ-028 busy_o = (state != IDLE).

Reset
REQ-029 rst=1 at a clock edge -> IDLE; all outputs 0, rdata registers 0, timeout counter 0, last_grant = m1 (m0 wins first contention).
REQ-030 rst SHALL override any state, including mid-REQ/RSP; the in-flight transaction is dropped without ack and late s_rvalid_i is ignored.

Verification
REQ-031 m0 read addr 0x10, slave gnt immediate, rvalid next cycle with 0x12345678 -> m0_ack_o one pulse 3 cycles after sampling, m0_rdata_o=0x12345678, m0_err_o=0.
REQ-032 Both masters request continuously, halt_i=0 -> grant order m0,m1,m0,m1; each ack a single cycle; no back-to-back double grant.
REQ-033 halt_i=1, both requesting -> only m0 served repeatedly; halt_i->0 -> m1 served at the next arbitration.
REQ-034 m1 write addr 0x100 data 0xA5A5A5A5, s_gnt_i delayed 2 cycles -> s_req_o/s_we_o=1 and s_addr_o/s_wdata_o stable for 3 cycles, m1_ack_o after s_rvalid_i, m1_rdata_o unchanged.
REQ-035 Slave never asserts s_gnt_i -> after 256 REQ cycles m0_ack_o=1, m0_err_o=1, m0_rdata_o=0, s_req_o=0, FSM back to IDLE.
REQ-036 rst pulsed during RSP, then s_rvalid_i asserted -> all outputs 0, no ack, busy_o=0.

Source files
------------

// File: rtl/jtag_mem_arbiter.sv
// jtag_mem_arbiter
//   Two-master, one-slave memory arbiter. Master 0 is the JTAG debug port,
//   master 1 is the CPU. Only one transaction is in flight at a time. Each
//   transaction walks IDLE -> REQ -> RSP -> DONE -> IDLE. The CPU is locked
//   out while the core is halted for debug.
//
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   halt_i                   1 = CPU halted, master 1 is not eligible
//   m0_* / m1_*              master request (level, held until ack),
//                            command fields, ack/err pulse, held read data
//   s_req_o .. s_wdata_o     slave command, held until s_gnt_i
//   s_gnt_i                  slave accepted the command
//   s_rvalid_i, s_rdata_i    slave completion and read data
//   busy_o                   arbiter not idle
//
// All outputs come straight from flops.
module jtag_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt_i,

    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    output logic [DATA_W-1:0] m0_rdata_o,

    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic [DATA_W-1:0] m1_rdata_o,

    output logic              s_req_o,
    output logic              s_we_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [DATA_W-1:0] s_wdata_o,
    input  logic              s_gnt_i,
    input  logic              s_rvalid_i,
    input  logic [DATA_W-1:0] s_rdata_i,

    output logic              busy_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RSP,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic             owner_q;       // 0 = m0, 1 = m1
    logic             last_grant_q;  // owner of the most recent grant
    logic             we_q;
    logic [CNT_W-1:0] cnt_q;

    logic elig0, elig1;
    logic grant;                     // arbitration happens this cycle
    logic grant_m1;                  // winner when grant = 1
    logic timeout_hit;
    logic to_err;                    // entering DONE because of timeout
    logic capture_rd;                // entering DONE on s_rvalid_i
    logic we_next;
    logic enter_wait;                // entering REQ or RSP from elsewhere

    // Master 1 is only eligible while the core is running.
    assign elig0 = m0_req_i;
    assign elig1 = m1_req_i & ~halt_i;

    // On contention the master that did not win last time wins now.
    assign grant_m1 = elig1 & (~elig0 | ~last_grant_q);

    // The counter starts at 0 on the first cycle of REQ/RSP. Reaching
    // TIMEOUT-1 means TIMEOUT cycles have been spent in the state.
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        grant      = 1'b0;
        to_err     = 1'b0;
        capture_rd = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (elig0 || elig1) begin
                    grant   = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // A grant on the last allowed cycle still counts.
                if (s_gnt_i) begin
                    state_d = S_RSP;
                end else if (timeout_hit) begin
                    state_d = S_DONE;
                    to_err  = 1'b1;
                end
            end
            S_RSP: begin
                if (s_rvalid_i) begin
                    state_d    = S_DONE;
                    capture_rd = 1'b1;
                end else if (timeout_hit) begin
                    state_d = S_DONE;
                    to_err  = 1'b1;
                end
            end
            S_DONE: begin
                // One-cycle completion. Requests are not sampled here.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The write enable the slave sees must already match the new owner
    // on the grant edge, before we_q has been loaded.
    assign we_next = grant ? (grant_m1 ? m1_we_i : m0_we_i) : we_q;

    assign enter_wait = ((state_d == S_REQ) && (state_q != S_REQ)) ||
                        ((state_d == S_RSP) && (state_q != S_RSP));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;    // m0 wins the first contention
            we_q         <= 1'b0;
            cnt_q        <= '0;
            s_req_o      <= 1'b0;
            s_we_o       <= 1'b0;
            s_addr_o     <= '0;
            s_wdata_o    <= '0;
            m0_ack_o     <= 1'b0;
            m0_err_o     <= 1'b0;
            m0_rdata_o   <= '0;
            m1_ack_o     <= 1'b0;
            m1_err_o     <= 1'b0;
            m1_rdata_o   <= '0;
            busy_o       <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_o  <= (state_d != S_IDLE);

            if (enter_wait) begin
                cnt_q <= '0;
            end else if ((state_q == S_REQ) || (state_q == S_RSP)) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (grant) begin
                owner_q      <= grant_m1;
                last_grant_q <= grant_m1;
                we_q         <= we_next;
                s_addr_o     <= grant_m1 ? m1_addr_i  : m0_addr_i;
                s_wdata_o    <= grant_m1 ? m1_wdata_i : m0_wdata_i;
            end

            // The command stays asserted for every cycle spent in REQ.
            s_req_o <= (state_d == S_REQ);
            s_we_o  <= (state_d == S_REQ) && we_next;

            // Completion goes only to the current owner.
            m0_ack_o <= (state_d == S_DONE) && !owner_q;
            m1_ack_o <= (state_d == S_DONE) &&  owner_q;
            m0_err_o <= to_err && !owner_q;
            m1_err_o <= to_err &&  owner_q;

            // Read data is held until that master's next read completes.
            // A timed-out transaction clears it, whether read or write.
            if (to_err) begin
                if (owner_q) m1_rdata_o <= '0;
                else         m0_rdata_o <= '0;
            end else if (capture_rd && !we_q) begin
                if (owner_q) m1_rdata_o <= s_rdata_i;
                else         m0_rdata_o <= s_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_jtag_mem_arbiter.sv
// tb_jtag_mem_arbiter
//   Scoreboard bench. Each master transaction pushes its expected
//   completion (err, rdata) onto that master's queue. A monitor pops the
//   entry and compares it when the ack arrives. A behavioural slave gives
//   configurable grant and response delays.
module tb_jtag_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          halt_i = 1'b0;
    logic          m0_req_i = 1'b0, m0_we_i = 1'b0;
    logic [AW-1:0] m0_addr_i = '0;
    logic [DW-1:0] m0_wdata_i = '0;
    logic          m0_ack_o, m0_err_o;
    logic [DW-1:0] m0_rdata_o;
    logic          m1_req_i = 1'b0, m1_we_i = 1'b0;
    logic [AW-1:0] m1_addr_i = '0;
    logic [DW-1:0] m1_wdata_i = '0;
    logic          m1_ack_o, m1_err_o;
    logic [DW-1:0] m1_rdata_o;
    logic          s_req_o, s_we_o;
    logic [AW-1:0] s_addr_o;
    logic [DW-1:0] s_wdata_o;
    logic          s_gnt_i = 1'b0, s_rvalid_i = 1'b0;
    logic [DW-1:0] s_rdata_i = '0;
    logic          busy_o;

    jtag_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .halt_i(halt_i),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
        .m0_wdata_i(m0_wdata_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
        .m1_wdata_i(m1_wdata_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .m1_rdata_o(m1_rdata_o),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
        .s_wdata_o(s_wdata_o), .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i),
        .s_rdata_i(s_rdata_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    typedef struct {
        logic          err;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t          q0[$], q1[$];
    logic [DW-1:0] mdl_rd[2];
    int            order_log[$];
    int            ack_cnt = 0;

    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        return (a == 32'h10) ? 32'h12345678 : {a[15:0], ~a[15:0]};
    endfunction

    // ---------------- slave model ----------------
    int            gnt_dly = 0, rv_dly = 0;
    bit            gnt_never = 0, stab_chk = 0;
    int            req_run = 0, last_req_len = 0, gcnt = 0, rcnt = 0;
    bit            pending = 0, pend_we = 0;
    logic [AW-1:0] pend_addr, hold_addr;
    logic [DW-1:0] hold_wdata;

    initial begin
        forever begin
            @(negedge clk);
            s_gnt_i    = 1'b0;
            s_rvalid_i = 1'b0;
            s_rdata_i  = 32'hDEADBEEF;
            if (pending) begin
                if (rcnt == rv_dly) begin
                    s_rvalid_i = 1'b1;
                    s_rdata_i  = pend_we ? 32'hBAD0BAD0 : mem_f(pend_addr);
                    pending    = 0;
                end else rcnt++;
            end else if (s_req_o) begin
                if (req_run == 0) begin
                    hold_addr  = s_addr_o;
                    hold_wdata = s_wdata_o;
                end else if (stab_chk) begin
                    chk("s_addr_stable", s_addr_o, hold_addr);
                    chk("s_wdata_stable", s_wdata_o, hold_wdata);
                    chk("s_we_held", s_we_o, 1);
                end
                req_run++;
                if (!gnt_never && gcnt == gnt_dly) begin
                    s_gnt_i   = 1'b1;
                    pending   = 1;
                    rcnt      = 0;
                    gcnt      = 0;
                    pend_addr = s_addr_o;
                    pend_we   = s_we_o;
                end else gcnt++;
            end
            if (!s_req_o && req_run > 0) begin
                last_req_len = req_run;
                req_run      = 0;
                gcnt         = 0;
            end
        end
    end

    // ---------------- completion monitor ----------------
    initial begin
        bit   prev_ack;
        exp_t e;
        prev_ack = 0;
        forever begin
            @(negedge clk);
            if (!rst && (m0_ack_o || m1_ack_o)) begin
                chk("one_owner", m0_ack_o & m1_ack_o, 0);
                chk("ack_pulse", prev_ack, 0);
                ack_cnt++;
                if (m0_ack_o) begin
                    order_log.push_back(0);
                    if (q0.size() == 0) chk("m0_unexpected_ack", 1, 0);
                    else begin
                        e = q0.pop_front();
                        chk("m0_err", m0_err_o, e.err);
                        chk("m0_rdata", m0_rdata_o, e.rdata);
                    end
                end else begin
                    order_log.push_back(1);
                    if (q1.size() == 0) chk("m1_unexpected_ack", 1, 0);
                    else begin
                        e = q1.pop_front();
                        chk("m1_err", m1_err_o, e.err);
                        chk("m1_rdata", m1_rdata_o, e.rdata);
                    end
                end
            end
            prev_ack = !rst && (m0_ack_o || m1_ack_o);
        end
    end

    // ---------------- master driver ----------------
    task automatic do_txn(input int m, input bit we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input bit exp_err, output int lat);
        exp_t e;
        bit   got;
        e.err = exp_err;
        if (exp_err) e.rdata = '0;
        else if (we) e.rdata = mdl_rd[m];
        else e.rdata = mem_f(addr);
        mdl_rd[m] = e.rdata;
        if (m == 0) begin
            q0.push_back(e);
            m0_req_i = 1; m0_we_i = we; m0_addr_i = addr; m0_wdata_i = wdata;
        end else begin
            q1.push_back(e);
            m1_req_i = 1; m1_we_i = we; m1_addr_i = addr; m1_wdata_i = wdata;
        end
        got = 0;
        lat = 0;
        for (int n = 1; n <= 700 && !got; n++) begin
            @(negedge clk);
            if ((m == 0) ? m0_ack_o : m1_ack_o) begin
                got = 1;
                lat = n;
            end
        end
        if (!got) chk("ack_wait_expired", 0, 1);
        if (m == 0) m0_req_i = 0; else m1_req_i = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        m0_req_i = 0;
        m1_req_i = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        mdl_rd[0] = '0;
        mdl_rd[1] = '0;
        q0.delete();
        q1.delete();
        order_log.delete();
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ctl"}, {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_req_o, s_we_o, busy_o}, 0);
        chk({tag, "_m0_rdata"}, m0_rdata_o, 0);
        chk({tag, "_m1_rdata"}, m1_rdata_o, 0);
        chk({tag, "_s_addr"}, s_addr_o, 0);
        chk({tag, "_s_wdata"}, s_wdata_o, 0);
    endtask

    initial begin
        int lat0, lat1, a, seen;
        mdl_rd[0] = '0;
        mdl_rd[1] = '0;
        do_reset();
        chk_idle_outputs("reset");

        // Single m0 read, zero-wait slave.
        do_txn(0, 0, 32'h10, 0, 0, lat0);
        chk("m0_read_latency", lat0, 3);
        @(negedge clk);
        chk("m0_rdata_held", m0_rdata_o, 32'h12345678);
        chk("idle_after_done", busy_o, 0);

        // Round robin with both masters requesting continuously.
        do_reset();
        fork
            begin
                do_txn(0, 0, 32'h200, 0, 0, lat0);
                do_txn(0, 0, 32'h204, 0, 0, lat0);
            end
            begin
                do_txn(1, 0, 32'h300, 0, 0, lat1);
                do_txn(1, 0, 32'h304, 0, 0, lat1);
            end
        join
        chk("rr_count", order_log.size(), 4);
        if (order_log.size() == 4) begin
            chk("rr_0", order_log[0], 0);
            chk("rr_1", order_log[1], 1);
            chk("rr_2", order_log[2], 0);
            chk("rr_3", order_log[3], 1);
        end

        // Halt locks out m1 until it drops.
        order_log.delete();
        @(negedge clk);
        halt_i = 1;
        fork
            begin
                do_txn(0, 0, 32'h400, 0, 0, lat0);
                do_txn(0, 0, 32'h404, 0, 0, lat0);
                do_txn(0, 0, 32'h408, 0, 0, lat0);
                halt_i = 0;
            end
            do_txn(1, 0, 32'h500, 0, 0, lat1);
        join
        chk("halt_count", order_log.size(), 4);
        if (order_log.size() == 4) begin
            chk("halt_0", order_log[0], 0);
            chk("halt_1", order_log[1], 0);
            chk("halt_2", order_log[2], 0);
            chk("halt_3", order_log[3], 1);
        end

        // m1 write with delayed grant. The halt raised mid-flight must not abort it.
        @(negedge clk);
        gnt_dly  = 2;
        stab_chk = 1;
        fork
            do_txn(1, 1, 32'h100, 32'hA5A5A5A5, 0, lat1);
            begin
                repeat (2) @(negedge clk);
                halt_i = 1;
            end
        join
        @(negedge clk);
        chk("wr_req_len", last_req_len, 3);
        chk("wr_cmd_addr", hold_addr, 32'h100);
        chk("wr_cmd_wdata", hold_wdata, 32'hA5A5A5A5);
        chk("m1_rdata_after_write", m1_rdata_o, mem_f(32'h500));
        halt_i   = 0;
        stab_chk = 0;
        gnt_dly  = 0;

        // Slave never grants: the transaction times out.
        gnt_never = 1;
        do_txn(0, 0, 32'h40, 0, 1, lat0);
        chk("to_m0_rdata", m0_rdata_o, 0);
        @(negedge clk);
        chk("to_req_len", last_req_len, TO);
        chk("to_s_req", s_req_o, 0);
        chk("to_busy", busy_o, 0);
        gnt_never = 0;

        // Reset during RSP. The late rvalid must be ignored.
        rv_dly   = 3;
        m0_addr_i = 32'h20;
        m0_we_i  = 0;
        m0_req_i = 1;
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (busy_o && !s_req_o) seen = 1;
        end
        chk("reached_rsp", seen, 1);
        a = ack_cnt;
        rst = 1;
        m0_req_i = 0;
        q0.delete();
        @(negedge clk);
        rst = 0;
        chk_idle_outputs("rst_mid");
        repeat (6) @(negedge clk);
        chk("rst_no_ack", ack_cnt, a);
        chk("rst_busy", busy_o, 0);
        chk("rst_m0_rdata", m0_rdata_o, 0);
        rv_dly = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
